// File: rtl/rx_frontend.sv
// UART receive front end: synchronises the serial line, derives a 16x oversample tick
// from a fractional accumulator and deframes start/data/parity/stop into a byte plus flags.
module rx_frontend (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] cr_acc_incr_i,
    input  logic        cr_ds_i,
    input  logic [1:0]  cr_p_i,
    input  logic        cr_s_i,
    input  logic        uart_rx_i,
    output logic [7:0]  dr_o,
    output logic        valid_o,
    output logic        pe_o,
    output logic        fe_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        DONE,
        BREAK
    } state_t;

    state_t      state_q;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] acc;
    logic [16:0] acc_sum;
    logic        tick;
    logic [3:0]  cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        ds_q;
    logic [1:0]  p_q;
    logic        s_q;
    logic        pe_q;
    logic        fe_q;
    logic        parity_en;
    logic [2:0]  last_idx;
    logic        parity_err;

    // The tick is the carry out of the 16-bit accumulator.
    assign acc_sum    = {1'b0, acc} + {1'b0, cr_acc_incr_i};
    assign tick       = acc_sum[16];
    assign parity_en  = p_q[0] ^ p_q[1];
    assign last_idx   = ds_q ? 3'd6 : 3'd7;
    assign parity_err = p_q[1] ? ~^{shreg, rx_s} : ^{shreg, rx_s};

    // NOTE: every register below is assigned with <= so that all reads in this block
    // see the pre-edge value; a later assignment in the same branch overrides an earlier one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            ds_q    <= 1'b0;
            p_q     <= 2'b00;
            s_q     <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            dr_o    <= '0;
            valid_o <= 1'b0;
            pe_o    <= 1'b0;
            fe_o    <= 1'b0;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
            acc     <= acc_sum[15:0];
            valid_o <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        // Restart the phase at the start edge; this cycle's tick is dropped.
                        state_q <= START;
                        acc     <= '0;
                        cnt     <= '0;
                        idx     <= '0;
                        shreg   <= '0;
                        pe_q    <= 1'b0;
                        fe_q    <= 1'b0;
                        ds_q    <= cr_ds_i;
                        p_q     <= cr_p_i;
                        s_q     <= cr_s_i;
                    end
                end

                START: begin
                    if (tick) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            if (rx_s) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= DATA;
                                cnt     <= '0;
                            end
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            shreg[idx] <= rx_s;
                            idx        <= idx + 3'd1;
                            if (idx == last_idx) begin
                                state_q <= parity_en ? PARITY : STOP1;
                            end
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            pe_q    <= parity_err;
                            state_q <= STOP1;
                        end
                    end
                end

                STOP1: begin
                    if (tick) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            if (s_q) begin
                                fe_q    <= ~rx_s;
                                state_q <= STOP2;
                            end else begin
                                state_q <= DONE;
                                valid_o <= 1'b1;
                                dr_o    <= shreg;
                                pe_o    <= pe_q;
                                fe_o    <= ~rx_s;
                            end
                        end
                    end
                end

                STOP2: begin
                    if (tick) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state_q <= DONE;
                            valid_o <= 1'b1;
                            dr_o    <= shreg;
                            pe_o    <= pe_q;
                            fe_o    <= fe_q | ~rx_s;
                        end
                    end
                end

                DONE: begin
                    // A framing error parks in BREAK so a held-low line cannot retrigger.
                    state_q <= fe_o ? BREAK : IDLE;
                end

                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frontend.sv
// Self-checking bench for rx_frontend: directed frames from the test plan plus randomised
// frames, each checked against the value the frame was built to carry.
module tb_rx_frontend;

    logic        clk;
    logic        rst;
    logic [15:0] incr;
    logic        ds;
    logic [1:0]  par;
    logic        two_stop;
    logic        rx;
    logic [7:0]  dr_o;
    logic        valid_o;
    logic        pe_o;
    logic        fe_o;

    typedef struct {
        logic [7:0] dr;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_valid = 0;
    int   n_expected = 0;
    int   bt = 256;

    rx_frontend dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cr_acc_incr_i (incr),
        .cr_ds_i       (ds),
        .cr_p_i        (par),
        .cr_s_i        (two_stop),
        .uart_rx_i     (rx),
        .dr_o          (dr_o),
        .valid_o       (valid_o),
        .pe_o          (pe_o),
        .fe_o          (fe_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Every received byte is matched against the oldest frame still owed.
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dr", {24'd0, dr_o}, {24'd0, e.dr});
                check("pe", {31'd0, pe_o}, {31'd0, e.pe});
                check("fe", {31'd0, fe_o}, {31'd0, e.fe});
            end
        end
    end

    task automatic bit_out(input logic b, input int clks);
        rx = b;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic set_baud(input logic [15:0] v);
        incr = v;
        bt   = 1048576 / int'(v);
    endtask

    // Builds one frame on the line; the expected result is derived from the frame itself.
    task automatic send_frame(input logic [7:0] d, input logic f_ds, input logic [1:0] f_p,
                              input logic f_s, input logic par_good, input logic stop1_v,
                              input logic stop2_v, input logic expect_it, input logic scramble);
        int         nbits;
        logic [7:0] dm;
        logic       pbit;
        logic       p_en;
        exp_t       e;
        nbits = f_ds ? 7 : 8;
        dm    = f_ds ? {1'b0, d[6:0]} : d;
        p_en  = (f_p == 2'b01) || (f_p == 2'b10);
        pbit  = (f_p == 2'b01) ? ^dm : ~^dm;
        if (!par_good) pbit = ~pbit;
        e.dr = dm;
        e.pe = p_en && !par_good;
        e.fe = !stop1_v || (f_s && !stop2_v);
        ds = f_ds;
        par = f_p;
        two_stop = f_s;
        if (expect_it) begin
            exp_q.push_back(e);
            n_expected++;
        end
        bit_out(1'b0, bt / 2);
        if (scramble) begin
            ds       = 1'($urandom);
            par      = 2'($urandom);
            two_stop = 1'($urandom);
        end
        bit_out(1'b0, bt - bt / 2);
        for (int i = 0; i < nbits; i++) bit_out(dm[i], bt);
        if (p_en) bit_out(pbit, bt);
        bit_out(stop1_v, bt);
        if (f_s) bit_out(stop2_v, bt);
        // The byte must have been presented before the nominal end of the frame.
        if (expect_it) check("valid_in_frame", exp_q.size(), 32'd0);
    endtask

    initial begin
        int v0;
        rst = 1'b1;
        rx = 1'b1;
        ds = 1'b0;
        par = 2'b00;
        two_stop = 1'b0;
        set_baud(16'h1000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_dr", {24'd0, dr_o}, 32'd0);
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_pe", {31'd0, pe_o}, 32'd0);
        check("reset_fe", {31'd0, fe_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bit_out(1'b1, 2 * bt);

        // 8N1, two frames back to back
        v0 = n_valid;
        send_frame(8'hA5, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        bit_out(1'b1, bt);
        check("b2b_count", n_valid - v0, 32'd2);

        // 7E2 good and bad parity, 8O1 bad and good parity
        send_frame(8'h55, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h00, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        bit_out(1'b1, bt);

        // Break: stop bit low, line held low for three more bit times
        send_frame(8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        v0 = n_valid;
        bit_out(1'b0, 3 * bt);
        check("break_quiet", n_valid - v0, 32'd0);
        bit_out(1'b1, bt);
        send_frame(8'h81, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        bit_out(1'b1, bt);

        // Glitch shorter than half a bit
        v0 = n_valid;
        bit_out(1'b0, 64);
        bit_out(1'b1, 2 * bt);
        check("glitch_quiet", n_valid - v0, 32'd0);

        // Reset during the data bits of an 0xFF frame
        v0 = n_valid;
        fork
            send_frame(8'hFF, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            begin
                repeat (3 * bt + 20) @(posedge clk);
                #1;
                rst = 1'b1;
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("midrst_dr", {24'd0, dr_o}, 32'd0);
                check("midrst_valid", {31'd0, valid_o}, 32'd0);
                check("midrst_pe", {31'd0, pe_o}, 32'd0);
                check("midrst_fe", {31'd0, fe_o}, 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        bit_out(1'b1, bt);
        check("aborted_quiet", n_valid - v0, 32'd0);
        send_frame(8'h12, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        bit_out(1'b1, bt);

        // Randomised frames at a faster baud
        set_baud(16'h2000);
        bit_out(1'b1, bt);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] d;
            logic       f_ds, f_s, pg, s1, s2, scr;
            logic [1:0] f_p;
            d    = 8'($urandom);
            f_ds = 1'($urandom);
            f_p  = 2'($urandom);
            f_s  = 1'($urandom);
            pg   = ($urandom_range(3) != 0);
            s1   = ($urandom_range(7) != 0);
            s2   = ($urandom_range(7) != 0);
            scr  = 1'($urandom);
            send_frame(d, f_ds, f_p, f_s, pg, s1, s2, 1'b1, scr);
            if (!s1 || (f_s && !s2)) bit_out(1'b1, bt);
            else if ($urandom_range(1) != 0) bit_out(1'b1, bt / 2);
        end

        bit_out(1'b1, 2 * bt);
        check("leftover", exp_q.size(), 32'd0);
        check("valid_total", n_valid, n_expected);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_frontend.md
# rx_frontend

UART receive front end: the receive-side counterpart of `tx_frontend`, driven by the same control-register fields.
- Synchronises the asynchronous `uart_rx_i` line and recovers bit timing with a 16x-oversampling fractional baud accumulator.
- Deframes start/data/parity/stop bits according to the configured frame format.
- Presents each received byte with one-cycle `valid_o` plus error flags to the register/FIFO layer above it.

## Interface
Parameters: none.
- `clk_i`  in  1  system clock; all logic on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `cr_acc_incr_i`  in  16  accumulator increment; one oversample tick per 16-bit accumulator carry (tick rate = 16 x baud)
- `cr_ds_i`  in  1  data size: 0 = 8 data bits, 1 = 7 data bits
- `cr_p_i`  in  2  parity: 00 none, 01 even, 10 odd, 11 none
- `cr_s_i`  in  1  stop bits: 0 = one, 1 = two
- `uart_rx_i`  in  1  serial input, asynchronous, idle high
- `dr_o`  out  8  received data, LSB-first assembly; bit 7 = 0 in 7-bit mode
- `valid_o`  out  1  one-cycle pulse: `dr_o`, `pe_o` and `fe_o` are valid
- `pe_o`  out  1  parity error for the frame flagged by `valid_o`
- `fe_o`  out  1  framing error (a stop bit sampled low) for the frame flagged by `valid_o`

## Operation
- Input path: 2-FF synchroniser on `uart_rx_i`; the FSM sees only the synchronised bit `rx_s`.
- Oversample tick:
  - 16-bit accumulator `acc += cr_acc_incr_i` every cycle; `tick` = carry-out, width-truncated wrap.
  - Accumulator is cleared to 0 on start detection, which aligns the sample phase to the start edge.
  - `cr_acc_incr_i = 0` → no ticks, so the FSM stalls in its current bit state.
- 4-bit tick counter `cnt` counts ticks within a bit.
- Config latch: `cr_ds_i`, `cr_p_i` and `cr_s_i` are captured on start detection and are held for the whole frame. Changes mid-frame take effect on the next frame.
- FSM register `state_q`; states and transitions:
  - IDLE: `rx_s == 0` → START; clear acc, `cnt`, shift register.
  - START: on the 8th tick (mid-bit):
    - `rx_s == 1` → false start, back to IDLE, no `valid_o`.
    - `rx_s == 0` → DATA, `cnt = 0`.
  - DATA: sample `rx_s` on every 16th tick (mid-bit) and shift it into bit position `idx`. After bit 7 (or bit 6 in 7-bit mode):
    - parity enabled → PARITY
    - otherwise → STOP1
  - PARITY: sample at mid-bit.
    - Even: `pe = ^(data, parity_bit)`.
    - Odd: `pe = ~^(data, parity_bit)`.
    - Then → STOP1.
  - STOP1: sample at mid-bit; `fe = (rx_s == 0)`.
    - `cr_s_i` latched as 1 → STOP2.
    - Otherwise → DONE.
  - STOP2: sample at mid-bit; `fe |= (rx_s == 0)`; → DONE.
  - DONE: single cycle; drive `valid_o = 1`.
    - `fe == 1` → BREAK.
    - Otherwise → IDLE.
  - BREAK: wait for `rx_s == 1`, then → IDLE. This prevents a held-low line from retriggering.
- `dr_o`, `pe_o` and `fe_o` are registered. They update in the DONE cycle and hold until the next DONE.
- No receive backpressure: the consumer must take data on the `valid_o` cycle. Overrun detection is handled by the layer above.

## Timing
- Reset values: `state_q` = IDLE, acc = 0, `cnt` = 0, `dr_o` = 0x00, `valid_o` = 0, `pe_o` = 0, `fe_o` = 0; synchroniser FFs = 1.
- Reset asserted mid-frame aborts immediately. The next frame needs a fresh falling edge after reset is released.
- Start-detect latency: 2 cycles of synchroniser delay plus 1 cycle to register IDLE→START.
- Bit period = 16 ticks. Each bit is sampled on its 8th tick relative to the bit boundary.
- `valid_o` rises 1 cycle after the last stop-bit mid-sample, i.e. about half a bit before the nominal frame end.
- Back-to-back frames: a start edge arriving in the second half of the stop bit is detected, because IDLE is re-entered at mid-stop.
- Simultaneous events: the tick in the cycle a start is detected is discarded (acc is cleared). Reset has priority over all other events.

## Test plan
- 8N1, `cr_acc_incr_i = 0x1000` (tick every 16 clk, 256 clk/bit), send 0xA5 → exactly one `valid_o` pulse, `dr_o = 0xA5`, `pe_o = 0`, `fe_o = 0`. Then send 0x3C back-to-back → second pulse with `dr_o = 0x3C`.
- 7E2 (`cr_ds_i = 1`, `cr_p_i = 01`, `cr_s_i = 1`), send 0x55 with correct parity bit 0 → `dr_o = 0x55`, `pe_o = 0`. Repeat with parity bit 1 → `pe_o = 1`, data still 0x55.
- 8O1, send 0x00 with wrong parity bit 0 → `pe_o = 1`; with parity bit 1 → `pe_o = 0`.
- 8N1 with stop bit driven 0 and the line then held low for 3 bit times → `valid_o` with `fe_o = 1`, `state_q` stays in BREAK, no further `valid_o` until the line returns high. A following 0x81 frame is received correctly.
- Glitch: low pulse of 64 clk (under half a bit) on an idle line → no `valid_o`, FSM returns to IDLE.
- Reset mid-DATA of a 0xFF frame, then send 0x12 → all outputs 0 during reset, no `valid_o` for the aborted frame, then `dr_o = 0x12`.
